baby_ram_arbiter: RTL and testbench

BABY_RAM_ARBITER -- requirements
Module: baby_ram_arbiter

---
 rtl/baby_ram_pkg.sv | 20 ++
 rtl/ram_arb_picker.sv | 27 ++
 rtl/baby_ram_arbiter.sv | 122 ++++++++++++
 tb/tb_baby_ram_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/baby_ram_pkg.sv
// Shared widths, FSM state encoding and request payload for the two-port RAM arbiter.
package baby_ram_pkg;

    localparam int unsigned ADDR_W    = 5;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned NUM_PORTS = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

endpackage

// File: rtl/ram_arb_picker.sv
// Two-way priority pick producing a one-hot grant.
// RAM_ARB_ROUND_ROBIN_EN selects round-robin between the two ports; otherwise port 0 always wins.
module ram_arb_picker
    import baby_ram_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req_i,
`ifdef RAM_ARB_ROUND_ROBIN_EN
    input  logic                 last_i,
`endif
    output logic [NUM_PORTS-1:0] gnt_o
);

    always_comb begin
        gnt_o = '0;
        if (req_i[0] && req_i[1]) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
            // Favour the port that did not win the previous acceptance.
            gnt_o = last_i ? NUM_PORTS'(2'b01) : NUM_PORTS'(2'b10);
`else
            gnt_o = NUM_PORTS'(2'b01);
`endif
        end else begin
            gnt_o = req_i;
        end
    end

endmodule

// File: rtl/baby_ram_arbiter.sv
// Arbitrates a CPU port and an SPI debug port onto one synchronous 32x32 RAM.
// RAM_ARB_ROUND_ROBIN_EN enables round-robin arbitration; undefined gives fixed port-0 priority.
module baby_ram_arbiter
    import baby_ram_pkg::*;
(
    input  logic              clock,
    input  logic              reset_i,
    input  logic              p0_req_i,
    input  logic              p0_we_i,
    input  logic [ADDR_W-1:0] p0_addr_i,
    input  logic [DATA_W-1:0] p0_wdata_i,
    output logic              p0_gnt_o,
    output logic              p0_rvalid_o,
    output logic [DATA_W-1:0] p0_rdata_o,
    input  logic              p1_req_i,
    input  logic              p1_we_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [DATA_W-1:0] p1_wdata_i,
    output logic              p1_gnt_o,
    output logic              p1_rvalid_o,
    output logic [DATA_W-1:0] p1_rdata_o,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_data_o,
    input  logic [DATA_W-1:0] ram_data_i
);

    state_e                 state_q;
    logic                   owner_q;
    logic                   ram_we_q;
    logic [ADDR_W-1:0]      ram_addr_q;
    logic [DATA_W-1:0]      ram_data_q;
    logic [NUM_PORTS-1:0]   rvalid_q;
    logic [DATA_W-1:0]      rdata_q [NUM_PORTS];
    logic [NUM_PORTS-1:0]   req_vec;
    logic [NUM_PORTS-1:0]   pick;
    logic [NUM_PORTS-1:0]   gnt_vec;
    req_t                   p0_req;
    req_t                   p1_req;
    req_t                   sel_req;

`ifdef RAM_ARB_ROUND_ROBIN_EN
    logic                   last_q;
`endif

    assign req_vec = {p1_req_i, p0_req_i};
    assign p0_req  = '{we: p0_we_i, addr: p0_addr_i, wdata: p0_wdata_i};
    assign p1_req  = '{we: p1_we_i, addr: p1_addr_i, wdata: p1_wdata_i};

    ram_arb_picker u_picker (
        .req_i  (req_vec),
`ifdef RAM_ARB_ROUND_ROBIN_EN
        .last_i (last_q),
`endif
        .gnt_o  (pick)
    );

    // Grants are only offered in IDLE and are forced low while reset is asserted.
    always_comb begin
        gnt_vec = '0;
        if (state_q == IDLE && !reset_i) begin
            gnt_vec = pick;
        end
        sel_req = gnt_vec[1] ? p1_req : p0_req;
    end

    assign p0_gnt_o    = gnt_vec[0];
    assign p1_gnt_o    = gnt_vec[1];
    assign p0_rvalid_o = rvalid_q[0];
    assign p1_rvalid_o = rvalid_q[1];
    assign p0_rdata_o  = rdata_q[0];
    assign p1_rdata_o  = rdata_q[1];
    assign ram_we_o    = ram_we_q;
    assign ram_addr_o  = ram_addr_q;
    assign ram_data_o  = ram_data_q;

    // The RAM-facing registers double as the latched request; they hold outside ACCESS.
    always_ff @(posedge clock or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_data_q <= '0;
            rvalid_q   <= '0;
            rdata_q[0] <= '0;
            rdata_q[1] <= '0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
            last_q     <= 1'b1;
`endif
        end else begin
            rvalid_q <= '0;
            ram_we_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (|gnt_vec) begin
                        owner_q    <= gnt_vec[1];
                        ram_we_q   <= sel_req.we;
                        ram_addr_q <= sel_req.addr;
                        ram_data_q <= sel_req.wdata;
`ifdef RAM_ARB_ROUND_ROBIN_EN
                        last_q     <= gnt_vec[1];
`endif
                        state_q    <= ACCESS;
                    end
                end
                ACCESS: begin
                    state_q <= ram_we_q ? IDLE : RESP;
                end
                RESP: begin
                    rdata_q[owner_q]  <= ram_data_i;
                    rvalid_q[owner_q] <= 1'b1;
                    state_q           <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_baby_ram_arbiter.sv
// Scoreboard bench for baby_ram_arbiter with a behavioural RAM and a transaction-level model.
module tb_baby_ram_arbiter;

    logic        clock = 1'b0;
    logic        reset_i;
    logic        p0_req_i, p0_we_i, p1_req_i, p1_we_i;
    logic [4:0]  p0_addr_i, p1_addr_i;
    logic [31:0] p0_wdata_i, p1_wdata_i;
    logic        p0_gnt_o, p0_rvalid_o, p1_gnt_o, p1_rvalid_o;
    logic [31:0] p0_rdata_o, p1_rdata_o;
    logic        ram_we_o;
    logic [4:0]  ram_addr_o;
    logic [31:0] ram_data_o;
    logic [31:0] ram_data_i;

    int n_checks = 0;
    int n_fail   = 0;

    baby_ram_arbiter dut (
        .clock(clock), .reset_i(reset_i),
        .p0_req_i(p0_req_i), .p0_we_i(p0_we_i), .p0_addr_i(p0_addr_i), .p0_wdata_i(p0_wdata_i),
        .p0_gnt_o(p0_gnt_o), .p0_rvalid_o(p0_rvalid_o), .p0_rdata_o(p0_rdata_o),
        .p1_req_i(p1_req_i), .p1_we_i(p1_we_i), .p1_addr_i(p1_addr_i), .p1_wdata_i(p1_wdata_i),
        .p1_gnt_o(p1_gnt_o), .p1_rvalid_o(p1_rvalid_o), .p1_rdata_o(p1_rdata_o),
        .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o),
        .ram_data_i(ram_data_i)
    );

    always #5 clock = ~clock;

    // Synchronous-read RAM the arbiter drives.
    logic [31:0] ram_mem [32];
    always @(posedge clock) begin
        if (ram_we_o) ram_mem[ram_addr_o] <= ram_data_o;
        ram_data_i <= ram_mem[ram_addr_o];
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: memory image, busy time per access, expected read responses.
    typedef struct {
        logic        port;
        int          due;
        logic [31:0] data;
    } rd_t;

    logic [31:0] model_mem [32];
    rd_t         rq [$];
    int          cyc     = 0;
    int          busy    = 0;
    logic        pend_wr = 1'b0;
    logic [4:0]  pw_addr;
    logic [31:0] pw_data;
    logic [31:0] held0 = '0;
    logic [31:0] held1 = '0;
    logic        last  = 1'b1;

    always @(negedge clock) begin
        logic [1:0]  exp_gnt;
        logic [1:0]  exp_rv;
        logic        port;
        logic        we;
        logic [4:0]  a;
        logic [31:0] d;
        cyc++;
        if (reset_i) begin
            chk("rst_ctrl", {p1_gnt_o, p0_gnt_o, p1_rvalid_o, p0_rvalid_o, ram_we_o, ram_addr_o}, '0);
            chk("rst_wdata", ram_data_o, '0);
            chk("rst_rdata", {p1_rdata_o, p0_rdata_o}, '0);
            rq.delete();
            busy = 0; pend_wr = 1'b0; held0 = '0; held1 = '0; last = 1'b1;
        end else begin
            chk("ram_we", ram_we_o, pend_wr);
            if (pend_wr) begin
                chk("ram_addr", ram_addr_o, pw_addr);
                chk("ram_data", ram_data_o, pw_data);
            end
            pend_wr = 1'b0;
            exp_rv = 2'b00;
            if (rq.size() != 0 && rq[0].due == cyc) exp_rv = rq[0].port ? 2'b10 : 2'b01;
            chk("rvalid", {p1_rvalid_o, p0_rvalid_o}, exp_rv);
            if (exp_rv != 2'b00) begin
                if (rq[0].port) held1 = rq[0].data;
                else            held0 = rq[0].data;
                void'(rq.pop_front());
            end
            chk("p0_rdata", p0_rdata_o, held0);
            chk("p1_rdata", p1_rdata_o, held1);
            exp_gnt = 2'b00;
            if (busy != 0) busy--;
            else if (p0_req_i && p1_req_i) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
                exp_gnt = last ? 2'b01 : 2'b10;
`else
                exp_gnt = 2'b01;
`endif
            end else exp_gnt = {p1_req_i, p0_req_i};
            chk("gnt", {p1_gnt_o, p0_gnt_o}, exp_gnt);
            if (exp_gnt != 2'b00) begin
                port = exp_gnt[1];
                we   = port ? p1_we_i    : p0_we_i;
                a    = port ? p1_addr_i  : p0_addr_i;
                d    = port ? p1_wdata_i : p0_wdata_i;
                last = port;
                if (we) begin
                    model_mem[a] = d;
                    pend_wr = 1'b1; pw_addr = a; pw_data = d;
                    busy = 1;
                end else begin
                    rq.push_back('{port: port, due: cyc + 3, data: model_mem[a]});
                    busy = 2;
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_ports();
        p0_req_i = 1'b0; p0_we_i = 1'b0; p0_addr_i = '0; p0_wdata_i = '0;
        p1_req_i = 1'b0; p1_we_i = 1'b0; p1_addr_i = '0; p1_wdata_i = '0;
    endtask

    // Hold one port's request until granted, then drop it the cycle after acceptance.
    task automatic issue(input logic p, input logic we, input logic [4:0] a, input logic [31:0] d);
        bit done = 1'b0;
        if (p) begin p1_req_i = 1'b1; p1_we_i = we; p1_addr_i = a; p1_wdata_i = d; end
        else   begin p0_req_i = 1'b1; p0_we_i = we; p0_addr_i = a; p0_wdata_i = d; end
        for (int i = 0; i < 20 && !done; i++) begin
            #1;
            if ((p ? p1_gnt_o : p0_gnt_o) === 1'b1) done = 1'b1;
            next_cycle();
        end
        if (!done) chk("issue_timeout", 64'd0, 64'd1);
        if (p) p1_req_i = 1'b0;
        else   p0_req_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) begin
            ram_mem[i]   = '0;
            model_mem[i] = '0;
        end
        idle_ports();
        reset_i = 1'b1;
        repeat (3) next_cycle();
        reset_i = 1'b0;
        next_cycle();

        // Single-port write then read-back.
        issue(1'b0, 1'b1, 5'h03, 32'hDEADBEEF);
        issue(1'b0, 1'b0, 5'h03, 32'h0);
        repeat (4) next_cycle();

        // Port isolation at the top address.
        issue(1'b1, 1'b1, 5'h1F, 32'h12345678);
        issue(1'b0, 1'b0, 5'h1F, 32'h0);
        repeat (4) next_cycle();

        // Contention: both ports read continuously, then port 0 withdraws.
        p0_req_i = 1'b1; p0_we_i = 1'b0; p0_addr_i = 5'h03;
        p1_req_i = 1'b1; p1_we_i = 1'b0; p1_addr_i = 5'h1F;
        repeat (13) next_cycle();
        p0_req_i = 1'b0;
        repeat (6) next_cycle();
        idle_ports();
        repeat (4) next_cycle();

        // Port 1 pulses its request while port 0's write is in ACCESS.
        issue(1'b0, 1'b1, 5'h0A, 32'hA5A5_0F0F);
        p1_req_i = 1'b1; p1_we_i = 1'b1; p1_addr_i = 5'h0A; p1_wdata_i = 32'hBAD0_BAD0;
        next_cycle();
        p1_req_i = 1'b0;
        repeat (3) next_cycle();
        issue(1'b0, 1'b0, 5'h0A, 32'h0);
        repeat (4) next_cycle();

        // Reset asserted during RESP of a read.
        issue(1'b0, 1'b0, 5'h03, 32'h0);
        @(posedge clock);
        #2;
        reset_i = 1'b1;
        #1;
        chk("rst_async_ctrl", {p1_gnt_o, p0_gnt_o, p1_rvalid_o, p0_rvalid_o, ram_we_o, ram_addr_o}, '0);
        chk("rst_async_data", {p1_rdata_o, p0_rdata_o}, '0);
        chk("rst_async_wdata", ram_data_o, '0);
        next_cycle();
        reset_i = 1'b0;
        p0_req_i = 1'b1; p0_we_i = 1'b0; p0_addr_i = 5'h1F;
        p1_req_i = 1'b1; p1_we_i = 1'b0; p1_addr_i = 5'h0A;
        #1;
        chk("post_rst_first_gnt", {p1_gnt_o, p0_gnt_o}, 2'b01);
        repeat (6) next_cycle();
        idle_ports();
        repeat (4) next_cycle();

        // Randomized traffic on both ports.
        for (int i = 0; i < 600; i++) begin
            p0_req_i   = ($urandom_range(0, 99) < 45);
            p0_we_i    = 1'($urandom_range(0, 1));
            p0_addr_i  = ($urandom_range(0, 3) == 0) ? 5'h1F : 5'($urandom_range(0, 7));
            p0_wdata_i = $urandom;
            p1_req_i   = ($urandom_range(0, 99) < 45);
            p1_we_i    = 1'($urandom_range(0, 1));
            p1_addr_i  = ($urandom_range(0, 3) == 0) ? 5'h1F : 5'($urandom_range(0, 7));
            p1_wdata_i = $urandom;
            next_cycle();
        end
        idle_ports();
        repeat (8) next_cycle();
        chk("scoreboard_drained", 64'(rq.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
